// File: rtl/riscv.sv
// VeriRisc-style 8-bit accumulator CPU with a 32x8 unified memory; one instruction per 8 clocks.
// No flow control: runs freely from reset until a HALT is decoded, then freezes until reset.
module riscv_mem (
    input  logic       i_clk,
    input  logic       i_wr,
    input  logic [4:0] i_addr,
    input  logic [7:0] i_wdat,
    output logic [7:0] o_rdat
);
    logic [7:0] memory [0:31];

    assign o_rdat = memory[i_addr];

    always_ff @(posedge i_clk) begin
        if (i_wr) memory[i_addr] <= i_wdat;
    end
endmodule

module riscv (
    input  logic clk,
    input  logic rst,
    output logic halt
);
    typedef enum logic [2:0] {
        INST_ADDR, INST_FETCH, INST_LOAD, IDLE,
        OP_ADDR, OP_FETCH, ALU_OP, STORE
    } phase_t;

    localparam logic [2:0] OP_HALT = 3'd0, OP_SKZ = 3'd1, OP_ADD = 3'd2, OP_AND = 3'd3,
                           OP_XOR  = 3'd4, OP_LDA = 3'd5, OP_STO = 3'd6, OP_JMP = 3'd7;

    phase_t     r_phase;
    logic [4:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_acc;
    logic       r_halt;

    logic [2:0] w_opcode;
    logic [4:0] w_addr;
    logic [7:0] w_rdat;
    logic [7:0] w_alu;
    logic       w_zero;
    logic       w_aluop;
    logic       w_wr;

    assign w_opcode = r_ir[7:5];
    assign w_addr   = r_phase[2] ? r_ir[4:0] : r_pc;
    assign w_zero   = (r_acc == 8'h00);
    assign w_aluop  = (w_opcode == OP_ADD) || (w_opcode == OP_AND) ||
                      (w_opcode == OP_XOR) || (w_opcode == OP_LDA);
    assign w_wr     = (r_phase == STORE) && (w_opcode == OP_STO);
    assign halt     = r_halt & ~rst;

    always_comb begin
        w_alu = r_acc;
        case (w_opcode)
            OP_ADD:  w_alu = r_acc + w_rdat;
            OP_AND:  w_alu = r_acc & w_rdat;
            OP_XOR:  w_alu = r_acc ^ w_rdat;
            OP_LDA:  w_alu = w_rdat;
            default: w_alu = r_acc;
        endcase
    end

    riscv_mem mem (
        .i_clk  (clk),
        .i_wr   (w_wr),
        .i_addr (w_addr),
        .i_wdat (r_acc),
        .o_rdat (w_rdat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= INST_ADDR;
            r_pc    <= 5'd0;
            r_ir    <= 8'h00;
            r_acc   <= 8'h00;
            r_halt  <= 1'b0;
        end else if (!r_halt) begin
            r_phase <= phase_t'(r_phase + 3'd1);
            case (r_phase)
                INST_LOAD: r_ir <= w_rdat;
                // HALT lands on phase 4 entry; the halted state then freezes everything there.
                IDLE:      if (w_opcode == OP_HALT) r_halt <= 1'b1;
                OP_ADDR:   r_pc <= r_pc + 5'd1;
                ALU_OP:    if ((w_opcode == OP_SKZ) && w_zero) r_pc <= r_pc + 5'd1;
                STORE: begin
                    if (w_aluop) r_acc <= w_alu;
                    if (w_opcode == OP_JMP) r_pc <= r_ir[4:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv.sv
// Bench for riscv: directed programs plus random programs checked against an instruction-level model.
module tb_riscv;
    logic clk;
    logic rst;
    logic halt;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] prog  [32];
    logic [7:0] m_mem [32];
    logic [7:0] m_acc;
    logic [4:0] m_pc;

    riscv dut (.clk(clk), .rst(rst), .halt(halt));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] ins(input logic [2:0] op, input logic [4:0] a);
        return {op, a};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = 8'h00;
    endtask

    // Holds reset for a cycle while preloading memory, then releases on a falling edge.
    task automatic start_prog();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            dut.mem.memory[i] = prog[i];
            m_mem[i] = prog[i];
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Instruction-at-a-time interpreter; returns index of the executed HALT or -1.
    task automatic model_run(input int max_i, output int n_halt);
        logic [7:0] w;
        logic [2:0] op;
        logic [4:0] a;
        n_halt = -1;
        m_pc = 5'd0;
        m_acc = 8'h00;
        for (int k = 0; k < max_i; k++) begin
            w = m_mem[m_pc];
            op = w[7:5];
            a = w[4:0];
            if (op == 3'd0) begin
                n_halt = k;
                break;
            end
            m_pc = m_pc + 5'd1;
            case (op)
                3'd1: if (m_acc == 8'h00) m_pc = m_pc + 5'd1;
                3'd2: m_acc = m_acc + m_mem[a];
                3'd3: m_acc = m_acc & m_mem[a];
                3'd4: m_acc = m_acc ^ m_mem[a];
                3'd5: m_acc = m_mem[a];
                3'd6: m_mem[a] = m_acc;
                default: m_pc = a;
            endcase
        end
    endtask

    task automatic test_reset();
        clear_prog();
        rst = 1'b1;
        #1;
        n_cmp++; if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt_initial got=%b exp=0", halt); end
        start_prog();
        step(3);
        n_cmp++; if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt_early got=%b exp=0", halt); end
        step(1);
        n_cmp++; if (halt !== 1'b1) begin n_fail++; $display("FAIL reset_halt_edge4 got=%b exp=1", halt); end
        step(5);
        n_cmp++; if (halt !== 1'b1) begin n_fail++; $display("FAIL reset_halt_held got=%b exp=1", halt); end
        n_cmp++; if (dut.r_pc !== 5'd0) begin n_fail++; $display("FAIL reset_halt_pc got=%0d exp=0", dut.r_pc); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_async_halt got=%b exp=0", halt); end
        n_cmp++;
        if ({dut.r_pc, dut.r_ir, dut.r_acc, 3'(dut.r_phase)} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_state got pc=%0d ir=%h acc=%h ph=%0d exp all 0",
                     dut.r_pc, dut.r_ir, dut.r_acc, dut.r_phase);
        end
    endtask

    task automatic test_jmp();
        clear_prog();
        prog[0] = ins(3'd7, 5'd2);
        prog[1] = ins(3'd7, 5'd1);
        start_prog();
        step(11);
        n_cmp++; if (halt !== 1'b0) begin n_fail++; $display("FAIL jmp_early got=%b exp=0", halt); end
        step(2);
        n_cmp++; if (halt !== 1'b1) begin n_fail++; $display("FAIL jmp_halt got=%b exp=1", halt); end
        n_cmp++; if (dut.r_pc !== 5'd2) begin n_fail++; $display("FAIL jmp_pc got=%0d exp=2", dut.r_pc); end
    endtask

    task automatic test_skz();
        clear_prog();
        prog[0] = ins(3'd1, 5'd0);
        prog[1] = ins(3'd7, 5'd4);
        prog[4] = ins(3'd7, 5'd4);
        start_prog();
        step(11);
        n_cmp++; if (halt !== 1'b0) begin n_fail++; $display("FAIL skz_zero_early got=%b exp=0", halt); end
        step(2);
        n_cmp++; if (halt !== 1'b1) begin n_fail++; $display("FAIL skz_zero_halt got=%b exp=1", halt); end
        clear_prog();
        prog[0] = ins(3'd5, 5'd5);
        prog[1] = ins(3'd1, 5'd0);
        prog[2] = ins(3'd7, 5'd4);
        prog[5] = 8'h01;
        start_prog();
        step(27);
        n_cmp++; if (halt !== 1'b0) begin n_fail++; $display("FAIL skz_nonzero_early got=%b exp=0", halt); end
        step(1);
        n_cmp++; if (halt !== 1'b1) begin n_fail++; $display("FAIL skz_nonzero_halt got=%b exp=1", halt); end
        n_cmp++; if (dut.r_pc !== 5'd4) begin n_fail++; $display("FAIL skz_nonzero_pc got=%0d exp=4", dut.r_pc); end
    endtask

    task automatic test_lda();
        clear_prog();
        prog[0] = ins(3'd5, 5'd5);
        prog[1] = ins(3'd7, 5'd3);
        prog[3] = ins(3'd7, 5'd6);
        prog[5] = 8'hFF;
        start_prog();
        step(27);
        n_cmp++; if (halt !== 1'b0) begin n_fail++; $display("FAIL lda_early got=%b exp=0", halt); end
        step(2);
        n_cmp++; if (halt !== 1'b1) begin n_fail++; $display("FAIL lda_halt got=%b exp=1", halt); end
        n_cmp++; if (dut.r_acc !== 8'hFF) begin n_fail++; $display("FAIL lda_acc got=%h exp=ff", dut.r_acc); end
    endtask

    task automatic test_sto();
        clear_prog();
        prog[0] = ins(3'd5, 5'd7);
        prog[1] = ins(3'd6, 5'd8);
        prog[2] = ins(3'd5, 5'd9);
        prog[3] = ins(3'd1, 5'd0);
        prog[7] = 8'h7F;
        start_prog();
        step(35);
        n_cmp++; if (halt !== 1'b0) begin n_fail++; $display("FAIL sto_early got=%b exp=0", halt); end
        step(10);
        n_cmp++; if (halt !== 1'b1) begin n_fail++; $display("FAIL sto_halt got=%b exp=1", halt); end
        n_cmp++; if (dut.r_pc !== 5'd5) begin n_fail++; $display("FAIL sto_pc got=%0d exp=5", dut.r_pc); end
        n_cmp++; if (dut.mem.memory[8] !== 8'h7F) begin n_fail++; $display("FAIL sto_mem8 got=%h exp=7f", dut.mem.memory[8]); end
        rst = 1'b1;
        step(2);
        n_cmp++; if (dut.mem.memory[8] !== 8'h7F) begin n_fail++; $display("FAIL sto_mem_after_reset got=%h exp=7f", dut.mem.memory[8]); end
    endtask

    task automatic test_alu();
        logic [2:0] ops [3] = '{3'd3, 3'd2, 3'd4};
        logic [7:0] a7  [3] = '{8'h7D, 8'h92, 8'h92};
        logic [7:0] a8  [3] = '{8'h9E, 8'h57, 8'h87};
        logic [7:0] a9  [3] = '{8'h00, 8'h17, 8'h00};
        logic [7:0] r8  [3] = '{8'h1C, 8'hE9, 8'h15};
        for (int t = 0; t < 3; t++) begin
            clear_prog();
            prog[0] = ins(3'd5, 5'd7);
            prog[1] = ins(ops[t], 5'd8);
            prog[2] = ins(3'd6, 5'd8);
            prog[3] = ins(ops[t], (t == 2) ? 5'd8 : 5'd9);
            prog[4] = ins(3'd1, 5'd0);
            prog[5] = ins(3'd7, 5'd0);
            prog[7] = a7[t];
            prog[8] = a8[t];
            prog[9] = a9[t];
            start_prog();
            step(43);
            n_cmp++; if (halt !== 1'b0) begin n_fail++; $display("FAIL alu%0d_early got=%b exp=0", t, halt); end
            step(2);
            n_cmp++; if (halt !== 1'b1) begin n_fail++; $display("FAIL alu%0d_halt got=%b exp=1", t, halt); end
            n_cmp++; if (dut.mem.memory[8] !== r8[t]) begin n_fail++; $display("FAIL alu%0d_mem8 got=%h exp=%h", t, dut.mem.memory[8], r8[t]); end
            n_cmp++; if (dut.r_acc !== 8'h00) begin n_fail++; $display("FAIL alu%0d_acc got=%h exp=00", t, dut.r_acc); end
        end
    endtask

    task automatic test_random();
        int n_halt;
        int bad;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 32; i++) begin
                if ($urandom_range(0, 15) == 0) prog[i] = 8'h00;
                else prog[i] = {3'($urandom_range(1, 7)), 5'($urandom)};
            end
            start_prog();
            model_run(40, n_halt);
            if (n_halt >= 0) begin
                step(8 * n_halt + 3);
                n_cmp++; if (halt !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_early got=%b exp=0 n=%0d", t, halt, n_halt); end
                step(1);
                n_cmp++; if (halt !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_halt got=%b exp=1 n=%0d", t, halt, n_halt); end
                step(8);
            end else begin
                step(320);
                n_cmp++; if (halt !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_nohalt got=%b exp=0", t, halt); end
            end
            n_cmp++; if (dut.r_acc !== m_acc) begin n_fail++; $display("FAIL rnd%0d_acc got=%h exp=%h", t, dut.r_acc, m_acc); end
            n_cmp++; if (dut.r_pc !== m_pc) begin n_fail++; $display("FAIL rnd%0d_pc got=%0d exp=%0d", t, dut.r_pc, m_pc); end
            bad = 0;
            for (int i = 0; i < 32; i++) if (dut.mem.memory[i] !== m_mem[i]) bad++;
            n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL rnd%0d_mem got=%0d differing words exp=0", t, bad); end
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_jmp();
        test_skz();
        test_lda();
        test_sto();
        test_alu();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/riscv.md
Name: riscv

Overview:
- Simplified 8-bit accumulator CPU ("VeriRisc" style) with internal 32x8 unified instruction/data memory.
- Each instruction is 8 bits: opcode [7:5], operand address [4:0]. Every instruction executes in a fixed 8-phase cycle.
- Top-level block; its only output is a halt flag.
- Memory contents are preloaded externally by the bench through the hierarchical path mem.memory.

Parameters:
- None. Data width is fixed at 8, address width at 5, memory depth at 32.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- halt  output  1  high once a HALT instruction is decoded; held until reset

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset clears the following and does not touch memory:
  - pc (5b) = 0
  - ir (8b) = 0
  - acc (8b) = 0
  - phase = 0
  - halt = 0
- halt is 0 combinationally while rst=1.
- Memory:
  - Submodule instance named mem, holding array memory[0:31] of 8-bit words.
  - Asynchronous (combinational) read at the muxed address.
  - Synchronous write on the rising clk edge when wr=1.
- Address mux: selects pc in phases 0-3 and ir[4:0] in phases 4-7.
- Opcodes: HALT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = ADD/AND/XOR/LDA.
- Phase counter: 3 bits, 0..7, advances by 1 each clock and wraps 7->0. Actions take effect at the clock edge ending each phase:
  - 0 INST_ADDR: no action.
  - 1 INST_FETCH: read mem[pc].
  - 2 INST_LOAD: ir <= mem[pc].
  - 3 IDLE: no action.
  - 4 OP_ADDR:
    - If ir opcode = HALT: set halt=1, freeze phase at 4 and freeze all state until reset.
    - Otherwise: pc <= pc+1 (5-bit wrap 31->0).
  - 5 OP_FETCH: read mem[ir[4:0]] for ALUOP.
  - 6 ALU_OP: if SKZ and zero=1, pc <= pc+1 (skips the next instruction).
  - 7 STORE:
    - ALUOP: acc <= alu_out.
    - STO: mem[ir[4:0]] <= acc.
    - JMP: pc <= ir[4:0]. This overrides the earlier increment.
- Combinational ALU:
  - ADD: (acc + mem) mod 256, carry discarded.
  - AND: acc & mem.
  - XOR: acc ^ mem.
  - LDA: mem.
  - Any other opcode: acc.
- zero = (acc == 8'h00), evaluated combinationally from the current acc.
- Timing from reset release:
  - halt for a HALT at address 0 asserts at the 4th rising edge (phase 4 entry); at 5 clock periods it is guaranteed high.
  - The Nth executed instruction (N from 0) that is a HALT raises halt 8*N+4 edges after release.
- Reset mid-instruction: state restarts at phase 0 with pc=0. Any memory write already committed stays.
- Undefined operand bits (x) in SKZ/HALT must not affect behaviour.
- Writing to the address of a later instruction is allowed (self-modifying code); the change is visible on the next fetch.

Test Plan:
- Reset:
  - rst=1 with mem[0]=HALT -> halt=0 immediately.
  - Release reset, wait 5 periods -> halt=1 and stays 1.
- JMP: mem[0]=JMP 2, mem[2]=HALT; reset pulse 1 period, wait 13 periods -> halt=1 (pc skipped address 1).
- SKZ:
  - mem[0]=SKZ, mem[1]=JMP 4, mem[2]=HALT; acc=0 after reset, so address 1 is skipped.
  - Wait 13 periods -> halt=1.
  - Also verify that with acc nonzero SKZ falls through.
- LDA:
  - Program: mem[0]=LDA 5, mem[1]=JMP 3, mem[3]=JMP 6, mem[6]=HALT, mem[5]=FF.
  - Wait 29 periods -> halt=1, acc=FF.
- STO:
  - Program: LDA 7; STO 8; LDA 9; SKZ; HALT(addr4); HALT(addr5); data mem[7]=7F, mem[8]=0, mem[9]=0.
  - Wait 45 periods -> halt=1 and mem[8]=7F.
- ALU, each run as: LDA 7; op 8; STO 8; op2 9 (or 8); SKZ; JMP 0; HALT at 6. Each -> halt=1 within 45 periods.
  - AND: 7D&9E -> mem[8]=1C.
  - ADD: 92+57 -> mem[8]=E9 (mod 256).
  - XOR: 92^87 -> mem[8]=15, then XOR 8 -> acc=0.
